ask_channel_scheduler: RTL and testbench
========================================

Name: ask_channel_scheduler

Overview:
- Receive-side controller for the ASK board. Scans the ten receiver inputs R0..R9 round-robin, locks onto the first channel carrying carrier activity, and sequences bit-period demodulation on it.
- Assembles bits into words and pulses new_word to the HEX display logic.
- Releases the channel on carrier loss, then resumes scanning at the next channel.

Parameters:
- NCH, 10: number of receiver channels.
- DWELL, 64: clock cycles spent sampling each channel during scan.
- ACT_THRESH, 8: minimum rising edges within one dwell to lock a channel.
- BIT_CYCLES, 32: clock cycles per received bit.
- BIT_THRESH, 4: minimum rising edges within one bit period for bit=1.
- WORD_BITS, 8: bits per word.
- LOST_BITS, 8: consecutive 0 bits that declare carrier loss.

Ports:
- MAX10_CLK1_50, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset.
- rx_in, input, NCH: receiver inputs; bit i is Ri.
- enable, input, 1: run/stop control.
- ch_sel, output, 4: index of the channel currently scanned or locked.
- locked, output, 1: high while in RECV.
- demodulated, output, 1: last decided bit value.
- neg_demodulated, output, 1: always ~demodulated.
- word, output, WORD_BITS: last completed word, MSB received first.
- new_word, output, 1: one-cycle pulse when word updates.

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE, ch_sel=0, locked=0.
  - demodulated=0, neg_demodulated=1.
  - word=0, new_word=0.
  - All counters and the shift register cleared.
- Input conditioning:
  - rx_in passes through a 2-flop synchronizer per channel.
  - The edge detector compares the synchronized rx_in[ch_sel] with its previous sample.
  - On the first cycle after any ch_sel change or state entry, the previous sample is reloaded and no edge is counted.
- Edge counters saturate at 255.
- IDLE:
  - Outputs hold their values.
  - enable=1 -> SCAN with dwell counter=0 and edge count=0.
  - ch_sel is kept, not reset.
- SCAN:
  - The dwell counter increments every cycle.
  - On the cycle the dwell counter reaches DWELL-1, evaluate the edge count:
    - edges >= ACT_THRESH -> RECV on the same ch_sel. locked=1 next cycle; bit counter, cycle counter, shift register and zero-run counter are cleared.
    - Otherwise, ch_sel advances (NCH-1 wraps to 0), counters clear, and the FSM stays in SCAN.
- RECV:
  - The cycle counter runs 0..BIT_CYCLES-1 while rising edges are counted.
  - At BIT_CYCLES-1, bit = (edges >= BIT_THRESH).
  - demodulated takes the bit on the next clock edge, and the bit shifts into the LSB of the shift register.
  - The zero-run counter increments on bit=0 and clears on bit=1.
  - When WORD_BITS bits have been collected:
    - word <= completed shift value; new_word=1 for exactly one cycle.
    - The bit counter restarts; word boundaries are counted from lock.
  - Zero-run reaching LOST_BITS -> SCAN: locked=0, ch_sel advances with wrap, demodulated forced to 0.
- Simultaneous word completion and carrier loss on the same bit:
  - The word is emitted (new_word pulses) and the FSM goes to SCAN in the same transition.
- enable=0 in any state -> IDLE on the next clock edge:
  - locked=0.
  - The partial word is discarded; no new_word.
  - word and demodulated hold their values.
- Latency: a bit decision appears on demodulated 1 cycle after the end of its bit period. new_word coincides with demodulated for the last bit of the word.
- ch_sel is never >= NCH.

Test Plan:
- Reset mid-RECV: assert rst=0 during bit 3 -> all outputs immediately at reset values (neg_demodulated=1, ch_sel=0, locked=0). No new_word after release until relock.
- Scan skip: carrier (toggle every 2 cycles, 16 edges/dwell) on R3 only, enable=1 -> ch_sel steps 0,1,2,3 at 64-cycle intervals, then locked=1 on ch3 roughly 260 cycles after enable.
- Word receive: lock on R3, then gate the carrier per bit with pattern 0xA5 (carrier=1, 8 edges/bit; silence=0) -> word=0xA5 with a single-cycle new_word. demodulated follows 1,0,1,0,0,1,0,1.
- Threshold boundary: 3 edges in a bit period -> bit 0; 4 edges -> bit 1. In scan, 7 edges -> channel skipped; 8 edges -> locked.
- Carrier loss with wrap: lock on R9, then remove the carrier for 8 bit periods -> a word of 0x00 is emitted with new_word on the 8th period, locked=0, ch_sel=0, SCAN resumes.
- Enable drop: deassert enable after 5 bits of a word -> IDLE next cycle, locked=0, no new_word, word holds its previous value. Re-enable -> SCAN resumes at the same ch_sel.

Source files
------------

// File: rtl/ask_channel_scheduler_if.sv
// Receiver-side bundle between the ASK front end/display logic and the channel scheduler.
interface ask_channel_scheduler_if #(
   parameter int unsigned NCH       = 10,
   parameter int unsigned WORD_BITS = 8
);
   logic [NCH-1:0]       rx_in;
   logic                 enable;
   logic [3:0]           ch_sel;
   logic                 locked;
   logic                 demodulated;
   logic                 neg_demodulated;
   logic [WORD_BITS-1:0] word;
   logic                 new_word;

   // Stimulus/consumer side: drives receivers and run control, observes decoded data.
   modport master (
      output rx_in, enable,
      input  ch_sel, locked, demodulated, neg_demodulated, word, new_word
   );

   // Scheduler side.
   modport slave (
      input  rx_in, enable,
      output ch_sel, locked, demodulated, neg_demodulated, word, new_word
   );
endinterface

// File: rtl/ask_channel_scheduler.sv
// Round-robin ASK channel scanner: locks onto an active receiver, demodulates
// bit periods by rising-edge count, assembles words and releases on carrier loss.
module ask_channel_scheduler #(
   parameter int unsigned NCH        = 10,
   parameter int unsigned DWELL      = 64,
   parameter int unsigned ACT_THRESH = 8,
   parameter int unsigned BIT_CYCLES = 32,
   parameter int unsigned BIT_THRESH = 4,
   parameter int unsigned WORD_BITS  = 8,
   parameter int unsigned LOST_BITS  = 8
) (
   input logic                     MAX10_CLK1_50,
   input logic                     rst,
   ask_channel_scheduler_if.slave  bus
);

   localparam int unsigned CH_W  = 4;
   localparam int unsigned DW_W  = $clog2(DWELL);
   localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
   localparam int unsigned BC_W  = $clog2(WORD_BITS);
   localparam int unsigned ZR_W  = $clog2(LOST_BITS + 1);
   localparam int unsigned EC_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RECV = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NCH-1:0]       rx_s1_q, rx_s2_q;
   logic [CH_W-1:0]      ch_q, ch_d, ch_adv;
   logic [DW_W-1:0]      dwell_q, dwell_d;
   logic [EC_W-1:0]      edges_q, edges_d, edges_now;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [BC_W-1:0]      bit_q, bit_d;
   logic [WORD_BITS-2:0] shift_q, shift_d;
   logic [WORD_BITS-1:0] shift_nx;
   logic [ZR_W-1:0]      zr_q, zr_d, zr_nx;
   logic                 prev_q, prev_d;
   logic                 reload_q, reload_d;
   logic                 demod_q, demod_d;
   logic                 neg_q;
   logic                 locked_q;
   logic [WORD_BITS-1:0] word_q, word_d;
   logic                 new_word_q, new_word_d;
   logic                 cur, rise, bit_val;

   // Two-flop synchronizer on every receiver input.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         rx_s1_q <= '0;
         rx_s2_q <= '0;
      end else begin
         rx_s1_q <= bus.rx_in;
         rx_s2_q <= rx_s1_q;
      end
   end

   // Rising-edge detect on the selected channel; saturating edge count includes this cycle.
   always_comb begin
      cur       = rx_s2_q[ch_q];
      rise      = ~reload_q & cur & ~prev_q;
      edges_now = (edges_q == '1) ? edges_q : edges_q + EC_W'(rise);
      ch_adv    = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + CH_W'(1);
      bit_val   = (edges_now >= EC_W'(BIT_THRESH));
      shift_nx  = {shift_q, bit_val};
      zr_nx     = bit_val ? '0 : zr_q + ZR_W'(1);
   end

   // Next-state and datapath updates for scan, lock and bit/word assembly.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      dwell_d    = dwell_q;
      edges_d    = edges_now;
      cyc_d      = cyc_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      zr_d       = zr_q;
      demod_d    = demod_q;
      word_d     = word_q;
      new_word_d = 1'b0;
      prev_d     = cur;

      if (!bus.enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SCAN;
               dwell_d = '0;
               edges_d = '0;
            end
            SCAN: begin
               dwell_d = dwell_q + DW_W'(1);
               if (dwell_q == DW_W'(DWELL - 1)) begin
                  dwell_d = '0;
                  edges_d = '0;
                  if (edges_now >= EC_W'(ACT_THRESH)) begin
                     state_d = RECV;
                     cyc_d   = '0;
                     bit_d   = '0;
                     shift_d = '0;
                     zr_d    = '0;
                  end else begin
                     ch_d = ch_adv;
                  end
               end
            end
            RECV: begin
               cyc_d = cyc_q + CYC_W'(1);
               if (cyc_q == CYC_W'(BIT_CYCLES - 1)) begin
                  cyc_d   = '0;
                  edges_d = '0;
                  demod_d = bit_val;
                  shift_d = shift_nx[WORD_BITS-2:0];
                  zr_d    = zr_nx;
                  if (bit_q == BC_W'(WORD_BITS - 1)) begin
                     word_d     = shift_nx;
                     new_word_d = 1'b1;
                     bit_d      = '0;
                  end else begin
                     bit_d = bit_q + BC_W'(1);
                  end
                  // Carrier loss wins the state change even when a word completes on this bit.
                  if (zr_nx >= ZR_W'(LOST_BITS)) begin
                     state_d = SCAN;
                     ch_d    = ch_adv;
                     demod_d = 1'b0;
                     dwell_d = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Suppress a false edge right after a channel switch or state entry.
      reload_d = (state_d != state_q) || (ch_d != ch_q);
   end

   // State, counters and registered outputs.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         dwell_q    <= '0;
         edges_q    <= '0;
         cyc_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         zr_q       <= '0;
         prev_q     <= 1'b0;
         reload_q   <= 1'b1;
         demod_q    <= 1'b0;
         neg_q      <= 1'b1;
         locked_q   <= 1'b0;
         word_q     <= '0;
         new_word_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         dwell_q    <= dwell_d;
         edges_q    <= edges_d;
         cyc_q      <= cyc_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         zr_q       <= zr_d;
         prev_q     <= prev_d;
         reload_q   <= reload_d;
         demod_q    <= demod_d;
         neg_q      <= ~demod_d;
         locked_q   <= (state_d == RECV);
         word_q     <= word_d;
         new_word_q <= new_word_d;
      end
   end

   assign bus.ch_sel          = ch_q;
   assign bus.locked          = locked_q;
   assign bus.demodulated     = demod_q;
   assign bus.neg_demodulated = neg_q;
   assign bus.word            = word_q;
   assign bus.new_word        = new_word_q;

endmodule

// File: tb/tb_ask_channel_scheduler.sv
// Directed bench for ask_channel_scheduler: scan, lock, demodulation, word and loss handling.
module tb_ask_channel_scheduler;
   localparam int unsigned NCH = 10;
   localparam int unsigned WB  = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic [NCH-1:0] car_en;
   logic [NCH-1:0] man;
   logic [1:0] ph = 2'd0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ask_channel_scheduler_if #(.NCH(NCH), .WORD_BITS(WB)) bus ();

   ask_channel_scheduler dut (
      .MAX10_CLK1_50 (clk),
      .rst           (rst_n),
      .bus           (bus.slave)
   );

   // Carrier generator: toggles every 2 cycles (one rising edge per 4 cycles).
   always @(negedge clk) ph = ph + 2'd1;

   assign bus.rx_in  = (car_en & {NCH{ph[1]}}) | man;
   assign bus.enable = en;

   // One bit period aligned to the lock reference; k single-cycle pulses mid-period.
   task automatic drive_bit(input int ch, input int k, output logic nw_mid);
      nw_mid = 1'b0;
      for (int off = 0; off < 32; off++) begin
         man = '0;
         if (off >= 4 && off < 4 + 2 * k && ((off - 4) % 2) == 0) man[ch] = 1'b1;
         @(negedge clk);
         if (off < 31 && bus.new_word === 1'b1) nw_mid = 1'b1;
      end
      man = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; man = '0; car_en = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.ch_sel !== 4'd0) begin n_bad++; $display("FAIL reset_ch_sel got %0d want 0", bus.ch_sel); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.demodulated !== 1'b0) begin n_bad++; $display("FAIL reset_demod got %b want 0", bus.demodulated); end
      n_cmp++; if (bus.neg_demodulated !== 1'b1) begin n_bad++; $display("FAIL reset_neg_demod got %b want 1", bus.neg_demodulated); end
      n_cmp++; if (bus.word !== 8'h00) begin n_bad++; $display("FAIL reset_word got %h want 00", bus.word); end
      n_cmp++; if (bus.new_word !== 1'b0) begin n_bad++; $display("FAIL reset_new_word got %b want 0", bus.new_word); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // R0 gets 7 edges in its dwell (skipped), R1 gets 8 (locked).
   task automatic test_scan_threshold();
      int lock_m;
      logic [3:0] ch_at_lock;
      lock_m = -1; ch_at_lock = 4'hF;
      en = 1'b1;
      for (int m = 0; m <= 200; m++) begin
         man = '0;
         if (m >= 8 && m < 22 && ((m - 8) % 2) == 0) man[0] = 1'b1;
         if (m >= 72 && m < 88 && ((m - 72) % 2) == 0) man[1] = 1'b1;
         if (m == 32) begin
            n_cmp++; if (bus.ch_sel !== 4'd0) begin n_bad++; $display("FAIL scan7_ch0 got %0d want 0", bus.ch_sel); end
         end
         if (m == 96) begin
            n_cmp++; if (bus.ch_sel !== 4'd1) begin n_bad++; $display("FAIL scan7_skip got %0d want 1", bus.ch_sel); end
         end
         if (bus.locked === 1'b1) begin lock_m = m; ch_at_lock = bus.ch_sel; break; end
         @(negedge clk);
      end
      man = '0;
      n_cmp++; if (lock_m != 129) begin n_bad++; $display("FAIL scan8_lock_time got %0d want 129", lock_m); end
      n_cmp++; if (ch_at_lock !== 4'd1) begin n_bad++; $display("FAIL scan8_lock_ch got %0d want 1", ch_at_lock); end
      en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL scan8_disable got %b want 0", bus.locked); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Carrier on R3 only: ch_sel walks 0..3 at dwell intervals then locks.
   task automatic test_scan_skip();
      int lock_m;
      logic [3:0] ch_at_lock;
      lock_m = -1; ch_at_lock = 4'hF;
      car_en = '0; car_en[3] = 1'b1;
      en = 1'b1;
      for (int m = 0; m <= 400; m++) begin
         if (m == 32 || m == 96 || m == 160 || m == 224) begin
            n_cmp++;
            if (bus.ch_sel !== 4'((m - 32) / 64)) begin
               n_bad++; $display("FAIL scan_step m=%0d got %0d want %0d", m, bus.ch_sel, (m - 32) / 64);
            end
         end
         if (bus.locked === 1'b1) begin lock_m = m; ch_at_lock = bus.ch_sel; break; end
         @(negedge clk);
      end
      car_en = '0;
      n_cmp++; if (lock_m != 257) begin n_bad++; $display("FAIL scan_lock_time got %0d want 257", lock_m); end
      n_cmp++; if (ch_at_lock !== 4'd3) begin n_bad++; $display("FAIL scan_lock_ch got %0d want 3", ch_at_lock); end
   endtask

   task automatic test_word_receive();
      logic nw;
      logic b;
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         b = pat[7 - i];
         drive_bit(3, b ? 8 : 0, nw);
         n_cmp++; if (bus.demodulated !== b) begin n_bad++; $display("FAIL a5_demod bit%0d got %b want %b", i, bus.demodulated, b); end
         n_cmp++; if (bus.new_word !== (i == 7)) begin n_bad++; $display("FAIL a5_new_word bit%0d got %b want %b", i, bus.new_word, i == 7); end
         n_cmp++; if (nw !== 1'b0) begin n_bad++; $display("FAIL a5_stray_new_word bit%0d got 1 want 0", i); end
      end
      n_cmp++; if (bus.word !== 8'hA5) begin n_bad++; $display("FAIL a5_word got %h want a5", bus.word); end
      n_cmp++; if (bus.neg_demodulated !== 1'b0) begin n_bad++; $display("FAIL a5_neg_demod got %b want 0", bus.neg_demodulated); end
   endtask

   // Edge counts 3/4 around the bit threshold: 8,3,4,8,3,3,4,8 -> 0xB3.
   task automatic test_bit_threshold();
      logic nw;
      int k;
      logic [7:0] exp_bits;
      int edges [8] = '{8, 3, 4, 8, 3, 3, 4, 8};
      exp_bits = 8'hB3;
      for (int i = 0; i < 8; i++) begin
         k = edges[i];
         drive_bit(3, k, nw);
         n_cmp++; if (bus.demodulated !== exp_bits[7 - i]) begin n_bad++; $display("FAIL thr_demod edges=%0d got %b want %b", k, bus.demodulated, exp_bits[7 - i]); end
         n_cmp++; if (nw !== 1'b0) begin n_bad++; $display("FAIL thr_new_word_width bit%0d got 1 want 0", i); end
      end
      n_cmp++; if (bus.new_word !== 1'b1) begin n_bad++; $display("FAIL thr_new_word got %b want 1", bus.new_word); end
      n_cmp++; if (bus.word !== 8'hB3) begin n_bad++; $display("FAIL thr_word got %h want b3", bus.word); end
   endtask

   task automatic test_enable_drop();
      logic nw;
      logic seen_nw;
      int lock_m;
      logic [3:0] ch_at_lock;
      seen_nw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_bit(3, 8, nw);
         if (nw === 1'b1 || bus.new_word === 1'b1) seen_nw = 1'b1;
      end
      en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL drop_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.word !== 8'hB3) begin n_bad++; $display("FAIL drop_word got %h want b3", bus.word); end
      n_cmp++; if (bus.demodulated !== 1'b1) begin n_bad++; $display("FAIL drop_demod got %b want 1", bus.demodulated); end
      n_cmp++; if (bus.ch_sel !== 4'd3) begin n_bad++; $display("FAIL drop_ch got %0d want 3", bus.ch_sel); end
      for (int c = 0; c < 40; c++) begin
         if (bus.new_word === 1'b1 || bus.locked === 1'b1) seen_nw = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (seen_nw !== 1'b0) begin n_bad++; $display("FAIL drop_no_new_word got 1 want 0"); end
      // Re-enable with carrier on R9: scan restarts at ch3 and walks up to ch9.
      lock_m = -1; ch_at_lock = 4'hF;
      car_en = '0; car_en[9] = 1'b1;
      en = 1'b1;
      for (int m = 0; m <= 600; m++) begin
         if (m == 32) begin
            n_cmp++; if (bus.ch_sel !== 4'd3) begin n_bad++; $display("FAIL resume_ch got %0d want 3", bus.ch_sel); end
         end
         if (m == 96) begin
            n_cmp++; if (bus.ch_sel !== 4'd4) begin n_bad++; $display("FAIL resume_step got %0d want 4", bus.ch_sel); end
         end
         if (bus.locked === 1'b1) begin lock_m = m; ch_at_lock = bus.ch_sel; break; end
         @(negedge clk);
      end
      car_en = '0;
      n_cmp++; if (lock_m != 449) begin n_bad++; $display("FAIL r9_lock_time got %0d want 449", lock_m); end
      n_cmp++; if (ch_at_lock !== 4'd9) begin n_bad++; $display("FAIL r9_lock_ch got %0d want 9", ch_at_lock); end
   endtask

   task automatic test_carrier_loss_wrap();
      logic nw;
      logic seen_lock;
      for (int i = 0; i < 8; i++) begin
         drive_bit(9, 0, nw);
         if (i < 7) begin
            n_cmp++; if (bus.locked !== 1'b1 || bus.new_word !== 1'b0) begin
               n_bad++; $display("FAIL loss_early bit%0d locked=%b new_word=%b want 1/0", i, bus.locked, bus.new_word);
            end
         end
      end
      n_cmp++; if (bus.new_word !== 1'b1) begin n_bad++; $display("FAIL loss_new_word got %b want 1", bus.new_word); end
      n_cmp++; if (bus.word !== 8'h00) begin n_bad++; $display("FAIL loss_word got %h want 00", bus.word); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.ch_sel !== 4'd0) begin n_bad++; $display("FAIL loss_wrap_ch got %0d want 0", bus.ch_sel); end
      n_cmp++; if (bus.demodulated !== 1'b0 || bus.neg_demodulated !== 1'b1) begin
         n_bad++; $display("FAIL loss_demod got %b/%b want 0/1", bus.demodulated, bus.neg_demodulated);
      end
      seen_lock = 1'b0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (bus.locked === 1'b1) seen_lock = 1'b1;
      end
      n_cmp++; if (bus.ch_sel !== 4'd1 || seen_lock !== 1'b0) begin
         n_bad++; $display("FAIL loss_rescan ch=%0d locked_seen=%b want 1/0", bus.ch_sel, seen_lock);
      end
   endtask

   task automatic test_reset_mid_recv();
      logic nw;
      logic seen;
      int lock_m;
      logic [3:0] ch_at_lock;
      lock_m = -1; ch_at_lock = 4'hF;
      car_en = '0; car_en[2] = 1'b1;
      for (int m = 0; m <= 300; m++) begin
         if (bus.locked === 1'b1) begin lock_m = m; ch_at_lock = bus.ch_sel; break; end
         @(negedge clk);
      end
      car_en = '0;
      n_cmp++; if (lock_m < 0 || ch_at_lock !== 4'd2) begin n_bad++; $display("FAIL relock_r2 m=%0d ch=%0d want lock on 2", lock_m, ch_at_lock); end
      for (int i = 0; i < 3; i++) drive_bit(2, 8, nw);
      n_cmp++; if (bus.demodulated !== 1'b1) begin n_bad++; $display("FAIL pre_reset_demod got %b want 1", bus.demodulated); end
      for (int off = 0; off < 10; off++) begin
         man = '0;
         if (off >= 4 && (off % 2) == 0) man[2] = 1'b1;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.ch_sel !== 4'd0) begin n_bad++; $display("FAIL rst_mid_ch got %0d want 0", bus.ch_sel); end
      n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rst_mid_locked got %b want 0", bus.locked); end
      n_cmp++; if (bus.demodulated !== 1'b0) begin n_bad++; $display("FAIL rst_mid_demod got %b want 0", bus.demodulated); end
      n_cmp++; if (bus.neg_demodulated !== 1'b1) begin n_bad++; $display("FAIL rst_mid_neg got %b want 1", bus.neg_demodulated); end
      n_cmp++; if (bus.word !== 8'h00) begin n_bad++; $display("FAIL rst_mid_word got %h want 00", bus.word); end
      man = '0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.new_word === 1'b1 || bus.locked === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_new_word got 1 want 0"); end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; man = '0; car_en = '0;
      @(negedge clk);
      test_reset();
      test_scan_threshold();
      test_scan_skip();
      test_word_receive();
      test_bit_threshold();
      test_enable_drop();
      test_carrier_loss_wrap();
      test_reset_mid_recv();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
